// File: rtl/sum_stream_accumulator_if.sv
// Sum-in / total-out handshake bundle for sum_stream_accumulator.
// max_data exists only when SUM_STREAM_ACC_MAX_EN is defined.
interface sum_stream_accumulator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 13
);
    logic [DATA_WIDTH:0]  sum_data;
    logic                 sum_valid;
    logic                 sum_ready;
    logic [ACC_WIDTH-1:0] total_data;
    logic                 total_valid;
    logic                 total_ready;
`ifdef SUM_STREAM_ACC_MAX_EN
    logic [DATA_WIDTH:0]  max_data;
`endif

    modport slave (
        input  sum_data,
        input  sum_valid,
        output sum_ready,
        output total_data,
        output total_valid,
`ifdef SUM_STREAM_ACC_MAX_EN
        output max_data,
`endif
        input  total_ready
    );

    modport master (
        output sum_data,
        output sum_valid,
        input  sum_ready,
        input  total_data,
        input  total_valid,
`ifdef SUM_STREAM_ACC_MAX_EN
        input  max_data,
`endif
        output total_ready
    );
endinterface

// File: rtl/sum_stream_accumulator.sv
// Reduces each frame of STREAM_LENGTH adder sums to one registered total beat.
// Optional macro SUM_STREAM_ACC_MAX_EN adds max_data (largest sum accepted in the frame).
module sum_stream_accumulator #(
    parameter int DATA_WIDTH    = 8,
    parameter int STREAM_LENGTH = 16,
    parameter int ACC_WIDTH     = DATA_WIDTH + 1 + $clog2(STREAM_LENGTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    sum_stream_accumulator_if.slave bus,
    output logic [15:0]             total_count
);
    localparam int CNT_W = (STREAM_LENGTH > 1) ? $clog2(STREAM_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(STREAM_LENGTH - 1);

    typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_total_data;
    logic [ACC_WIDTH-1:0] w_acc_sum;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic                 r_sum_ready;
    logic                 r_total_valid;
    logic [15:0]          r_total_count;
    logic                 w_in_hs;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_out_hs;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake qualification; clear outranks both handshakes.
    always_comb begin
        w_next_state = r_state;
        w_in_hs      = 1'b0;
        w_out_hs     = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_in_hs = bus.sum_valid && r_sum_ready;
                if (clear) begin
                    w_next_state = ST_ACCUM;
                end else if (w_in_hs && (r_beat_cnt == LAST_BEAT)) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                w_out_hs = r_total_valid && bus.total_ready;
                if (clear || w_out_hs) begin
                    w_next_state = ST_ACCUM;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_ACCUM;
            end
        endcase
        w_accept  = w_in_hs && !clear;
        w_last    = w_accept && (r_beat_cnt == LAST_BEAT);
        w_acc_sum = r_acc + ACC_WIDTH'(bus.sum_data);
    end

    // Accumulator, beat counter and registered output stream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc         <= {ACC_WIDTH{1'b0}};
            r_beat_cnt    <= {CNT_W{1'b0}};
            r_sum_ready   <= 1'b0;
            r_total_data  <= {ACC_WIDTH{1'b0}};
            r_total_valid <= 1'b0;
            r_total_count <= 16'd0;
        end else begin
            // Ready is a pure decode of the upcoming state, so total_ready never reaches sum_ready combinationally.
            r_sum_ready <= (w_next_state == ST_ACCUM);
            if (clear) begin
                r_acc         <= {ACC_WIDTH{1'b0}};
                r_beat_cnt    <= {CNT_W{1'b0}};
                r_total_valid <= 1'b0;
            end else if (w_last) begin
                r_total_data  <= w_acc_sum;
                r_total_valid <= 1'b1;
                r_acc         <= {ACC_WIDTH{1'b0}};
                r_beat_cnt    <= {CNT_W{1'b0}};
            end else if (w_accept) begin
                r_acc      <= w_acc_sum;
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end else if (w_out_hs) begin
                r_total_valid <= 1'b0;
                r_total_count <= r_total_count + 16'd1;
            end else begin
                r_acc <= r_acc;
            end
        end
    end

`ifdef SUM_STREAM_ACC_MAX_EN
    logic [DATA_WIDTH:0] r_run_max;
    logic [DATA_WIDTH:0] r_max_data;
    logic [DATA_WIDTH:0] w_beat_max;

    // Running maximum including the beat currently presented.
    always_comb begin
        if (bus.sum_data > r_run_max) begin
            w_beat_max = bus.sum_data;
        end else begin
            w_beat_max = r_run_max;
        end
    end

    // Frame maximum tracks the same accept/last/clear events as the accumulator.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run_max  <= {(DATA_WIDTH + 1){1'b0}};
            r_max_data <= {(DATA_WIDTH + 1){1'b0}};
        end else if (clear) begin
            r_run_max  <= {(DATA_WIDTH + 1){1'b0}};
            r_max_data <= {(DATA_WIDTH + 1){1'b0}};
        end else if (w_last) begin
            r_run_max  <= {(DATA_WIDTH + 1){1'b0}};
            r_max_data <= w_beat_max;
        end else if (w_accept) begin
            r_run_max <= w_beat_max;
        end else begin
            r_run_max <= r_run_max;
        end
    end

    assign bus.max_data = r_max_data;
`endif

    assign bus.sum_ready   = r_sum_ready;
    assign bus.total_data  = r_total_data;
    assign bus.total_valid = r_total_valid;
    assign total_count     = r_total_count;
endmodule

// File: tb/tb_sum_stream_accumulator.sv
// Directed plus randomized frames for sum_stream_accumulator, checked against
// per-frame sums computed from the beat arrays the bench sends.
module tb_sum_stream_accumulator;
    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] total_count;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_count;
    logic [8:0]  fv [16];

    sum_stream_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(13)) bus ();

    sum_stream_accumulator #(
        .DATA_WIDTH(8),
        .STREAM_LENGTH(16),
        .ACC_WIDTH(13)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .bus(bus),
        .total_count(total_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat after gap idle cycles; returns on the negedge after its handshake.
    task automatic send_beat(input logic [8:0] v, input int gap);
        int n;
        bus.sum_valid = 1'b0;
        repeat (gap) @(negedge clock);
        bus.sum_valid = 1'b1;
        bus.sum_data  = v;
        n = 0;
        while (bus.sum_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            chk("beat_timeout", 32'(bus.sum_ready), 32'd1);
        end else begin
            @(negedge clock);
        end
        bus.sum_valid = 1'b0;
        bus.sum_data  = 9'($urandom);
    endtask

    // Send fv[0..15], check the total, optionally stall hold cycles, then optionally release it.
    task automatic run_frame(input string tag, input int max_gap, input int hold, input bit finish);
        int exp_sum;
`ifdef SUM_STREAM_ACC_MAX_EN
        logic [8:0] exp_max;
        exp_max = 9'd0;
        foreach (fv[i]) if (fv[i] > exp_max) exp_max = fv[i];
`endif
        exp_sum = 0;
        foreach (fv[i]) exp_sum += int'(fv[i]);
        bus.total_ready = (hold == 0) && finish;
        for (int i = 0; i < 16; i++) send_beat(fv[i], int'($urandom_range(max_gap, 0)));
        chk({tag, "_valid"}, 32'(bus.total_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.total_data), 32'(exp_sum));
`ifdef SUM_STREAM_ACC_MAX_EN
        chk({tag, "_max"}, 32'(bus.max_data), 32'(exp_max));
`endif
        for (int k = 0; k < hold; k++) begin
            bus.sum_valid = 1'b1;
            bus.sum_data  = 9'($urandom);
            @(negedge clock);
            chk({tag, "_hold_valid"}, 32'(bus.total_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(bus.total_data), 32'(exp_sum));
            chk({tag, "_hold_ready"}, 32'(bus.sum_ready), 32'd0);
        end
        bus.sum_valid = 1'b0;
        if (finish) begin
            bus.total_ready = 1'b1;
            @(negedge clock);
            exp_count = exp_count + 16'd1;
            chk({tag, "_done_valid"}, 32'(bus.total_valid), 32'd0);
            chk({tag, "_count"}, 32'(total_count), 32'(exp_count));
            chk({tag, "_ready"}, 32'(bus.sum_ready), 32'd1);
        end
    endtask

    initial begin
        reset           = 1'b0;
        clear           = 1'b0;
        bus.sum_valid   = 1'b0;
        bus.sum_data    = 9'd0;
        bus.total_ready = 1'b0;
        exp_count       = 16'd0;
        repeat (3) @(negedge clock);
        chk("rst_sum_ready", 32'(bus.sum_ready), 32'd0);
        chk("rst_total_valid", 32'(bus.total_valid), 32'd0);
        chk("rst_total_data", 32'(bus.total_data), 32'd0);
        chk("rst_total_count", 32'(total_count), 32'd0);
        reset = 1'b1;

        foreach (fv[i]) fv[i] = 9'd15;
        run_frame("nominal", 0, 0, 1'b1);

        foreach (fv[i]) fv[i] = 9'd510;
        run_frame("maxval", 0, 0, 1'b1);

        foreach (fv[i]) fv[i] = 9'($urandom);
        run_frame("bp_hold", 0, 5, 1'b1);
        foreach (fv[i]) fv[i] = 9'd255;
        run_frame("bp_next", 0, 0, 1'b1);

        for (int i = 0; i < 5; i++) send_beat(9'd100, 0);
        bus.sum_valid = 1'b1;
        bus.sum_data  = 9'd77;
        clear         = 1'b1;
        @(negedge clock);
        clear         = 1'b0;
        bus.sum_valid = 1'b0;
        foreach (fv[i]) fv[i] = 9'd1;
        run_frame("clr_accum", 0, 0, 1'b1);

        foreach (fv[i]) fv[i] = 9'($urandom);
        run_frame("clr_hold", 1, 0, 1'b0);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clr_hold_valid", 32'(bus.total_valid), 32'd0);
        chk("clr_hold_count", 32'(total_count), 32'(exp_count));
        chk("clr_hold_ready", 32'(bus.sum_ready), 32'd1);

        for (int i = 0; i < 7; i++) send_beat(9'($urandom), 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_sum_ready", 32'(bus.sum_ready), 32'd0);
        chk("arst_total_data", 32'(bus.total_data), 32'd0);
        chk("arst_total_valid", 32'(bus.total_valid), 32'd0);
        chk("arst_total_count", 32'(total_count), 32'd0);
        @(negedge clock);
        reset     = 1'b1;
        exp_count = 16'd0;
        foreach (fv[i]) fv[i] = 9'd15;
        run_frame("post_rst", 0, 0, 1'b1);

        foreach (fv[i]) fv[i] = 9'(i);
        run_frame("bubbles", 3, 0, 1'b1);

        for (int f = 0; f < 4; f++) begin
            foreach (fv[i]) fv[i] = 9'($urandom);
            run_frame("rand", 2, int'($urandom_range(3, 0)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
